// File: rtl/seq_pkg.sv
// seq_pkg -- shared types and constants for the multicycle sequencer.
//   state_e  : sequencer FSM states
//   iclass_e : instruction class produced by seq_decode
//   OP_*     : opcode field values, each sized to the IR field it is compared against
package seq_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [3:0] {
    C_LDUR, C_STUR, C_ADD, C_SUB, C_AND, C_ORR, C_CBZ, C_B, C_MOVZ, C_BAD
  } iclass_e;

  // IR[31:21]
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  // IR[31:24], IR[31:26], IR[31:23]
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;
  localparam logic [8:0]  OP_MOVZ = 9'h1A5;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if -- instruction and data memory handshakes.
//   imem_req/imem_ack/imem_data : fetch request, ack, 32-bit instruction word
//   dmem_req/dmem_we/dmem_ack   : data access request, store select, ack
//   master : the sequencer side; slave : the memory side
interface multicycle_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (output imem_req, input imem_ack, input imem_data,
                  output dmem_req, output dmem_we, input dmem_ack);
  modport slave  (input imem_req, output imem_ack, output imem_data,
                  input dmem_req, input dmem_we, output dmem_ack);
endinterface

// File: rtl/seq_decode.sv
// seq_decode -- combinational IR-to-class decoder.
//   ir  : latched instruction register
//   cls : instruction class; C_BAD for anything unrecognised
// Full 11-bit opcodes are checked before the shorter CBZ/B/MOVZ fields.
module seq_decode
  import seq_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_e     cls
);

  always_comb begin
    cls = C_BAD;
    if      (ir[31:21] == OP_LDUR) cls = C_LDUR;
    else if (ir[31:21] == OP_STUR) cls = C_STUR;
    else if (ir[31:21] == OP_ADD)  cls = C_ADD;
    else if (ir[31:21] == OP_SUB)  cls = C_SUB;
    else if (ir[31:21] == OP_AND)  cls = C_AND;
    else if (ir[31:21] == OP_ORR)  cls = C_ORR;
    else if (ir[31:24] == OP_CBZ)  cls = C_CBZ;
    else if (ir[31:26] == OP_B)    cls = C_B;
    else if (ir[31:23] == OP_MOVZ) cls = C_MOVZ;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer -- FETCH/DECODE/EXEC/MEM/WB control sequencer.
//   CLK, resetl (async, active-low)
//   startpc   : PC loaded while in reset
//   currentpc : address of the instruction in flight
//   bus       : imem/dmem handshakes (master modport)
//   instr     : latched instruction register
//   extimm, alu_zero : immediate and zero flag derived from instr
//   regwrite, mem2reg : write-back strobe and source select
//   retired, halt, fault : retire pulse, halted, halted on error
// Optional macro SEQ_WATCHDOG_EN adds a WDOG_W-bit handshake watchdog;
// without it the sequencer waits for ack indefinitely.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int WDOG_W = 8
) (
  input  logic                   CLK,
  input  logic                   resetl,
  input  logic [XLEN-1:0]        startpc,
  output logic [XLEN-1:0]        currentpc,
  multicycle_sequencer_if.master bus,
  output logic [31:0]            instr,
  input  logic [XLEN-1:0]        extimm,
  input  logic                   alu_zero,
  output logic                   regwrite,
  output logic                   mem2reg,
  output logic                   retired,
  output logic                   halt,
  output logic                   fault
);

  state_e          state, state_n;
  iclass_e         cls;
  logic            taken;
  logic            wdog_to;
  logic [XLEN-1:0] pc_n;

  seq_decode u_dec (.ir(instr), .cls(cls));

`ifdef SEQ_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = '1 - WDOG_W'(1);
  logic [WDOG_W-1:0] wdog;
  logic              waiting;

  assign waiting = (state == FETCH && !bus.imem_ack) || (state == MEM && !bus.dmem_ack);
  // Fires on the waiting cycle whose edge would take the count to all-ones.
  assign wdog_to = waiting && (wdog == WDOG_LAST);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl)               wdog <= '0;
    else if (state_n != state) wdog <= '0;
    else if (waiting)          wdog <= wdog + WDOG_W'(1);
  end
`else
  assign wdog_to = 1'b0;
`endif

  assign taken = (cls == C_B) || (cls == C_CBZ && alu_zero);
  assign pc_n  = (state == EXEC && taken) ? currentpc + (extimm << 2)
                                          : currentpc + XLEN'(4);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state     <= FETCH;
      currentpc <= startpc;
      instr     <= '0;
    end else begin
      state <= state_n;
      if (retired) currentpc <= pc_n;
      if (state == FETCH && bus.imem_ack) instr <= bus.imem_data;
    end
  end

  always_comb begin
    state_n = state;
    retired = 1'b0;
    case (state)
      FETCH:  if (bus.imem_ack) state_n = DECODE;
              else if (wdog_to) state_n = HALT;
      DECODE: state_n = (cls == C_BAD) ? HALT : EXEC;
      EXEC: begin
        if (cls == C_B || cls == C_CBZ) begin
          state_n = FETCH;
          retired = 1'b1;
        end else if (cls == C_LDUR || cls == C_STUR) begin
          state_n = MEM;
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        if (bus.dmem_ack) begin
          if (cls == C_STUR) begin
            state_n = FETCH;
            retired = 1'b1;
          end else begin
            state_n = WB;
          end
        end else if (wdog_to) begin
          state_n = HALT;
        end
      end
      WB: begin
        state_n = FETCH;
        retired = 1'b1;
      end
      default: state_n = HALT;
    endcase
  end

  // State is forced to FETCH asynchronously, so only imem_req needs the
  // reset gate to stay low while resetl is held.
  assign bus.imem_req = resetl && (state == FETCH);
  assign bus.dmem_req = (state == MEM);
  assign bus.dmem_we  = (state == MEM) && (cls == C_STUR);
  assign regwrite     = (state == WB);
  assign mem2reg      = (state == WB) && (cls == C_LDUR);
  assign halt         = (state == HALT);
  // Every route into HALT is an error.
  assign fault        = (state == HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer -- directed bench for multicycle_sequencer
// (default build, watchdog disabled). The bench plays both memories.
module tb_multicycle_sequencer;

  localparam logic [31:0] I_ADD  = 32'h8B000000;
  localparam logic [31:0] I_SUB  = 32'hCB000000;
  localparam logic [31:0] I_LDUR = 32'hF8400000;
  localparam logic [31:0] I_STUR = 32'hF8000000;
  localparam logic [31:0] I_CBZ  = 32'hB4000000;
  localparam logic [31:0] I_B    = 32'h14000000;
  localparam logic [31:0] I_MOVZ = 32'hD2800000;

  logic        CLK = 1'b0;
  logic        resetl;
  logic [63:0] startpc, currentpc, extimm;
  logic        alu_zero;
  logic [31:0] instr;
  logic        regwrite, mem2reg, retired, halt, fault;

  multicycle_sequencer_if bus();

  multicycle_sequencer dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc), .currentpc(currentpc),
    .bus(bus), .instr(instr), .extimm(extimm), .alu_zero(alu_zero),
    .regwrite(regwrite), .mem2reg(mem2reg), .retired(retired),
    .halt(halt), .fault(fault)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int r_cyc, r_rw, r_dreq, r_we, r_m2r, cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one instruction from FETCH to its retire cycle. Acks come after
  // iwait/dwait stalled cycles of the matching request.
  task automatic run(input string tag, input logic [31:0] ir, input int iwait, input int dwait);
    int  iw = 0;
    int  dw = 0;
    bit  done = 0;
    r_cyc = 0; r_rw = 0; r_dreq = 0; r_we = 0; r_m2r = 0;
    while (!done && r_cyc < 100) begin
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      if (bus.imem_req) begin
        if (iw == iwait) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = ir;
        end
        iw++;
      end
      if (bus.dmem_req) begin
        r_dreq++;
        if (bus.dmem_we) r_we++;
        if (dw == dwait) bus.dmem_ack = 1'b1;
        dw++;
      end
      #1;
      r_cyc++;
      if (regwrite) r_rw++;
      if (regwrite && mem2reg) r_m2r++;
      if (retired) done = 1;
      tick();
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    chk({tag, ".retired"}, 64'(done), 64'd1);
  endtask

  initial begin
    resetl        = 1'b0;
    startpc       = 64'h100;
    extimm        = '0;
    alu_zero      = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    bus.dmem_ack  = 1'b0;
    #12;
    chk("rst.imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst.dmem_req", 64'(bus.dmem_req), 64'd0);
    chk("rst.pc",       currentpc, 64'h100);
    chk("rst.instr",    64'(instr), 64'd0);
    chk("rst.status",   {61'd0, retired, halt, fault}, 64'd0);
    tick();
    resetl = 1'b1;
    #1;
    chk("rel.imem_req", 64'(bus.imem_req), 64'd1);

    run("add", I_ADD, 0, 0);
    chk("add.cyc", 64'(r_cyc), 64'd4);
    chk("add.rw",  64'(r_rw),  64'd1);
    chk("add.m2r", 64'(r_m2r), 64'd0);
    chk("add.pc",  currentpc,  64'h104);
    chk("add.ir",  64'(instr), 64'(I_ADD));

    run("ldur", I_LDUR, 0, 3);
    chk("ldur.cyc",  64'(r_cyc),  64'd8);
    chk("ldur.dreq", 64'(r_dreq), 64'd4);
    chk("ldur.we",   64'(r_we),   64'd0);
    chk("ldur.m2r",  64'(r_m2r),  64'd1);
    chk("ldur.pc",   currentpc,   64'h108);

    run("stur", I_STUR, 0, 0);
    chk("stur.cyc", 64'(r_cyc), 64'd4);
    chk("stur.we",  64'(r_we),  64'd1);
    chk("stur.rw",  64'(r_rw),  64'd0);
    chk("stur.pc",  currentpc,  64'h10C);

    extimm = 64'd61;
    run("b", I_B, 0, 0);
    chk("b.cyc", 64'(r_cyc), 64'd3);
    chk("b.pc",  currentpc,  64'h200);

    extimm = -64'sd2; alu_zero = 1'b1;
    run("cbz1", I_CBZ, 0, 0);
    chk("cbz1.cyc", 64'(r_cyc), 64'd3);
    chk("cbz1.pc",  currentpc,  64'h1F8);

    extimm = 64'd2; alu_zero = 1'b0;
    run("b2", I_B, 0, 0);
    chk("b2.pc", currentpc, 64'h200);

    extimm = -64'sd2; alu_zero = 1'b0;
    run("cbz0", I_CBZ, 0, 0);
    chk("cbz0.cyc", 64'(r_cyc), 64'd3);
    chk("cbz0.pc",  currentpc,  64'h204);

    run("movz", I_MOVZ, 0, 0);
    chk("movz.cyc", 64'(r_cyc), 64'd4);
    chk("movz.rw",  64'(r_rw),  64'd1);
    chk("movz.pc",  currentpc,  64'h208);

    run("sub", I_SUB, 2, 0);
    chk("sub.cyc", 64'(r_cyc), 64'd6);
    chk("sub.pc",  currentpc,  64'h20C);

    // 0x20C - 0x210 wraps below zero
    extimm = -64'sd132;
    run("bwrap", I_B, 0, 0);
    chk("bwrap.pc", currentpc, 64'hFFFF_FFFF_FFFF_FFFC);
    run("addwrap", I_ADD, 0, 0);
    chk("addwrap.pc", currentpc, 64'h0);

    // No watchdog: fetch request held while ack never comes.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req) cnt++;
      tick();
    end
    chk("nowdog.req",  64'(cnt),  64'd40);
    chk("nowdog.halt", 64'(halt), 64'd0);

    // Illegal instruction halts with fault; ack held high is then ignored.
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'hFFFF_FFFF;
    tick();
    tick();
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.imem_req || retired || regwrite) cnt++;
      tick();
    end
    chk("bad.halt",  64'(halt),  64'd1);
    chk("bad.fault", 64'(fault), 64'd1);
    chk("bad.quiet", 64'(cnt),   64'd0);
    chk("bad.pc",    currentpc,  64'h0);

    // Reset out of HALT, then reset again in the middle of a load.
    bus.imem_ack = 1'b0;
    startpc = 64'h300;
    resetl = 1'b0;
    #2;
    chk("rst2.pc",   currentpc, 64'h300);
    chk("rst2.halt", 64'(halt), 64'd0);
    resetl = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.imem_data = I_LDUR;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    chk("mid.dreq", 64'(bus.dmem_req), 64'd1);
    tick();
    resetl = 1'b0;
    #1;
    chk("mid.rst.dreq",  64'(bus.dmem_req), 64'd0);
    chk("mid.rst.ireq",  64'(bus.imem_req), 64'd0);
    chk("mid.rst.instr", 64'(instr), 64'd0);
    bus.dmem_ack = 1'b1;
    #2;
    resetl = 1'b1;
    #1;
    chk("mid.rel.ireq", 64'(bus.imem_req), 64'd1);
    tick();
    chk("mid.late.ireq", 64'(bus.imem_req), 64'd1);
    chk("mid.late.dreq", 64'(bus.dmem_req), 64'd0);
    chk("mid.late.rw",   64'(regwrite),     64'd0);
    bus.dmem_ack = 1'b0;
    run("add2", I_ADD, 0, 0);
    chk("add2.cyc", 64'(r_cyc), 64'd4);
    chk("add2.pc",  currentpc,  64'h304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter XLEN, default 64, PC and immediate width.
REQ-002 Parameter WDOG_W, default 8, watchdog counter width.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 resetl  input  1  reset, asynchronous, active-low.
REQ-005 startpc  input  XLEN  PC loaded during reset.
REQ-006 currentpc  output  XLEN  address of instruction in flight.
REQ-007 imem_req / imem_ack / imem_data  output 1 / input 1 / input 32  instruction fetch handshake and data.
REQ-008 instr  output  32  latched instruction register (IR).
REQ-009 extimm / alu_zero  input XLEN / input 1  sign-extended immediate and ALU zero flag, both derived from IR.
REQ-010 dmem_req / dmem_we / dmem_ack  output 1 / output 1 / input 1  data memory handshake; dmem_we=1 for store.
REQ-011 regwrite / mem2reg  output 1 / output 1  register-file write strobe and write-back source select.
REQ-012 retired / halt / fault  output 1 each  retire pulse, halted, halted due to error.

Function
REQ-013 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 FETCH: imem_req=1 until a cycle with imem_ack=1; that edge latches imem_data into IR and moves to DECODE.
REQ-015 DECODE (1 cycle) classifies IR[31:21]: LDUR 0x7C2, STUR 0x7C0, ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550, CBZ IR[31:24]=0xB4, B IR[31:26]=0x05, MOVZ IR[31:23]=0x1A5; anything else -> HALT with fault=1.
REQ-016 EXEC (1 cycle): B and CBZ compute next PC here and return to FETCH; loads/stores -> MEM; ALU/MOVZ -> WB.
REQ-017 MEM: dmem_req=1 until dmem_ack=1; load -> WB, store -> FETCH; dmem_we=1 only in MEM for STUR.
REQ-018 WB (1 cycle): regwrite=1; mem2reg=1 only for LDUR.
REQ-019 Next PC = currentpc+4; B, or CBZ with alu_zero=1 sampled in EXEC: currentpc + (extimm<<2); arithmetic modulo 2^XLEN (wraps, no error).
REQ-020 currentpc updates only on the final edge of an instruction; retired pulses high for exactly that cycle.
REQ-021 Cycle counts with zero-wait ack: B/CBZ 3, ALU/MOVZ 4, STUR 4, LDUR 5.
REQ-022 ack while corresponding req is low SHALL be ignored; req never drops before ack.
REQ-023 HALT is terminal until reset; halt=1, all req/strobes 0, currentpc frozen.

Reset
REQ-024 resetl low SHALL immediately force FETCH, currentpc=startpc, IR=0, all req/strobe/status outputs 0.
REQ-025 Reset during a pending handshake drops req asynchronously; the late ack SHALL be ignored.
REQ-026 First cycle after resetl rises SHALL assert imem_req for startpc.

Configuration
REQ-027 Macro SEQ_WATCHDOG_EN defined: WDOG_W-bit counter clears on entering FETCH/MEM, increments each waiting cycle; reaching all-ones without ack -> HALT, fault=1.
REQ-028 SEQ_WATCHDOG_EN undefined: no counter, waits indefinitely for ack.

Structure
REQ-029 Package seq_pkg SHALL hold the state enum, instruction-class enum and opcode constants.
REQ-030 Sub-module seq_decode SHALL be the combinational IR-to-class decoder; FSM, PC and watchdog stay in multicycle_sequencer.

Verification
REQ-031 startpc=0x100, ADD with immediate ack -> retired after 4 cycles, currentpc=0x104, one regwrite pulse, mem2reg=0.
REQ-032 LDUR with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, WB mem2reg=1, total 8 cycles.
REQ-033 CBZ with alu_zero=1, extimm=-2 at currentpc=0x200 -> currentpc=0x1F8 after 3 cycles; alu_zero=0 -> 0x204.
REQ-034 IR=0xFFFFFFFF -> HALT, fault=1, halt=1, no further imem_req.
REQ-035 SEQ_WATCHDOG_EN, WDOG_W=4, imem_ack never high -> HALT with fault=1 after 15 wait cycles; without macro, imem_req held indefinitely.
REQ-036 resetl pulsed low mid-MEM, then dmem_ack -> req drops at once, ack ignored, fetch restarts at startpc.
